reg_sequencer: RTL

Multi-cycle micro-sequencer that sits directly upstream of the register file. It accepts one register-level operation at a time (instruction fetch, register move, push, pop) through a start/done handshake. For that operation it drives the register file's select, output-enable, load and SP/PC increment/decrement controls cycle by cycle, and handshakes with memory. Bus `a` carries the memory address and bus `b` carries write data. The register file's `in` port and the instruction register are fed from the memory/data bus outside this block.

---
 rtl/reg_sequencer_pkg.sv | 28 ++
 rtl/reg_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/reg_sequencer_pkg.sv
// Shared types and register-index helpers for the register-file micro-sequencer.
package reg_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MOV   = 2'd1,
        PUSH  = 2'd2,
        POP   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        XFER = 3'd1,
        DEC  = 3'd2,
        MEM  = 3'd3,
        DONE = 3'd4
    } state_e;

    // SP and PC live in the top two register slots.
    function automatic int sp_index(input int depth);
        return depth - 2;
    endfunction

    function automatic int pc_index(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/reg_sequencer.sv
// Micro-sequencer driving register-file selects/strobes and a memory handshake for FETCH/MOV/PUSH/POP.
// Latency: MOV and FETCH/POP 2 cycles, PUSH 3 cycles, plus one per memory wait cycle; mem_rd/mem_wr held until mem_ack.
module reg_sequencer
    import reg_sequencer_pkg::*;
#(
    parameter int SEL_WIDTH = 4,
    parameter int DEPTH     = 2**SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [SEL_WIDTH-1:0] src,
    input  logic [SEL_WIDTH-1:0] dst,
    output logic                 busy,
    output logic                 done,
    output logic [SEL_WIDTH-1:0] rf_sel_a,
    output logic [SEL_WIDTH-1:0] rf_sel_b,
    output logic [SEL_WIDTH-1:0] rf_sel_in,
    output logic                 rf_oe_a,
    output logic                 rf_oe_b,
    output logic                 rf_ld,
    output logic                 rf_post_inc_sp,
    output logic                 rf_pre_dec_sp,
    output logic                 rf_post_inc_pc,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic                 mem_ack,
    output logic                 ir_ld
);

    localparam logic [SEL_WIDTH-1:0] SP_SEL = SEL_WIDTH'(sp_index(DEPTH));
    localparam logic [SEL_WIDTH-1:0] PC_SEL = SEL_WIDTH'(pc_index(DEPTH));

    state_e               state;
    state_e               state_nxt;
    op_e                  op_q;
    logic [SEL_WIDTH-1:0] src_q;
    logic [SEL_WIDTH-1:0] dst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= FETCH;
            src_q <= '0;
            dst_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                op_q  <= op_e'(op);
                src_q <= src;
                dst_q <= dst;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        rf_sel_a       = '0;
        rf_sel_b       = '0;
        rf_sel_in      = '0;
        rf_oe_a        = 1'b0;
        rf_oe_b        = 1'b0;
        rf_ld          = 1'b0;
        rf_post_inc_sp = 1'b0;
        rf_pre_dec_sp  = 1'b0;
        rf_post_inc_pc = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        ir_ld          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op_e'(op))
                        FETCH:   state_nxt = MEM;
                        MOV:     state_nxt = XFER;
                        PUSH:    state_nxt = DEC;
                        POP:     state_nxt = MEM;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            XFER: begin
                busy      = 1'b1;
                rf_sel_b  = src_q;
                rf_oe_b   = 1'b1;
                rf_sel_in = dst_q;
                rf_ld     = 1'b1;
                state_nxt = DONE;
            end
            DEC: begin
                busy          = 1'b1;
                rf_pre_dec_sp = 1'b1;
                state_nxt     = MEM;
            end
            MEM: begin
                busy     = 1'b1;
                rf_oe_a  = 1'b1;
                rf_sel_a = (op_q == FETCH) ? PC_SEL : SP_SEL;
                case (op_q)
                    FETCH: begin
                        mem_rd = 1'b1;
                        if (mem_ack) begin
                            ir_ld          = 1'b1;
                            rf_post_inc_pc = 1'b1;
                        end
                    end
                    POP: begin
                        mem_rd = 1'b1;
                        if (mem_ack) begin
                            rf_sel_in = dst_q;
                            rf_ld     = 1'b1;
                            // Popping into SP: the loaded value must win over the increment.
                            rf_post_inc_sp = (dst_q != SP_SEL);
                        end
                    end
                    PUSH: begin
                        mem_wr   = 1'b1;
                        rf_sel_b = src_q;
                        rf_oe_b  = 1'b1;
                    end
                    default: ;
                endcase
                if (mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
